// File: rtl/pe0_stage_ctrl.sv
// rtl/pe0_stage_ctrl.sv - PE0 butterfly pass sequencer with latency-matched write-back
// Optional feature: define PE0_CTRL_BITREV_EN to bit-reverse the write-back address.
module pe0_stage_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int TW_W    = 7,
    parameter int N_BFLY  = 64,
    parameter int LAT_FWD = 4,
    parameter int LAT_INV = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [TW_W-1:0]   tw_base,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              sel_0,
    output logic              sel_1,
    output logic              KD_mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [TW_W-1:0]   tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BFLY - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [TW_W-1:0]   tw_base_q, tw_base_d;
    logic              kd_q, kd_d;
    logic              sel1_q, sel1_d;
    logic              sel0_q, sel0_d;
    logic              inv_q, inv_d;
    // Each tag is {valid, index}; entry k holds the tag pushed k cycles ago.
    logic [ADDR_W:0]   pipe_q [1:LAT_INV];
    logic [ADDR_W:0]   pipe_d [1:LAT_INV];

    logic [ADDR_W:0]   tap;
    logic              tap_valid;
    logic [ADDR_W-1:0] tap_idx;

    assign tap       = inv_q ? pipe_q[LAT_INV] : pipe_q[LAT_FWD];
    assign tap_valid = tap[ADDR_W];
    assign tap_idx   = tap[ADDR_W-1:0];

    assign rd_en   = (state_q == ISSUE) && !hold;
    assign rd_addr = i_q;
    assign tw_addr = tw_base_q + TW_W'(i_q);
    assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign sel_0   = sel0_q;
    assign sel_1   = sel1_q;
    assign KD_mode = kd_q;
    assign wr_en   = tap_valid;

`ifdef PE0_CTRL_BITREV_EN
    always_comb begin
        wr_addr = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            wr_addr[b] = tap_idx[ADDR_W-1-b];
        end
    end
`else
    assign wr_addr = tap_idx;
`endif

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        tw_base_d = tw_base_q;
        kd_d      = kd_q;
        sel1_d    = sel1_q;
        sel0_d    = sel0_q;
        inv_d     = inv_q;
        pipe_d[1] = {rd_en, i_q};
        for (int k = 2; k <= LAT_INV; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    kd_d      = mode[2];
                    sel1_d    = mode[1];
                    sel0_d    = mode[0];
                    inv_d     = ~mode[2] & mode[1];
                    tw_base_d = tw_base;
                    i_d       = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    i_d = i_q + 1'b1;
                    if (i_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final tag sits at the tap this cycle; done follows next cycle.
                if (tap_valid && (tap_idx == LAST_IDX)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            tw_base_q <= '0;
            kd_q      <= 1'b0;
            sel1_q    <= 1'b0;
            sel0_q    <= 1'b0;
            inv_q     <= 1'b0;
            for (int k = 1; k <= LAT_INV; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            tw_base_q <= tw_base_d;
            kd_q      <= kd_d;
            sel1_q    <= sel1_d;
            sel0_q    <= sel0_d;
            inv_q     <= inv_d;
            for (int k = 1; k <= LAT_INV; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pe0_stage_ctrl.sv
// tb/tb_pe0_stage_ctrl.sv - directed self-checking bench for pe0_stage_ctrl
module tb_pe0_stage_ctrl;

    localparam int ADDR_W  = 6;
    localparam int TW_W    = 7;
    localparam int N_BFLY  = 64;
    localparam int LAT_FWD = 4;
    localparam int LAT_INV = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        mode;
    logic [TW_W-1:0]   tw_base;
    logic              hold;
    logic              busy, done, sel_0, sel_1, KD_mode;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [TW_W-1:0]   tw_addr;

    int total = 0;
    int bad   = 0;

    pe0_stage_ctrl #(
        .ADDR_W(ADDR_W), .TW_W(TW_W), .N_BFLY(N_BFLY),
        .LAT_FWD(LAT_FWD), .LAT_INV(LAT_INV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .tw_base(tw_base),
        .hold(hold), .busy(busy), .done(done), .sel_0(sel_0), .sel_1(sel_1),
        .KD_mode(KD_mode), .rd_en(rd_en), .rd_addr(rd_addr), .tw_addr(tw_addr),
        .wr_en(wr_en), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_wr_addr(input int idx);
`ifdef PE0_CTRL_BITREV_EN
        int r = 0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (((idx >> b) & 1) != 0) r = r | (1 << (ADDR_W - 1 - b));
        end
        return r;
`else
        return idx;
`endif
    endfunction

    function automatic int out_word();
        return int'({busy, done, sel_0, sel_1, KD_mode, rd_en, wr_en}) + int'(rd_addr)
             + int'(tw_addr) + int'(wr_addr);
    endfunction

    // Cycle 0 is the cycle in which start is first presented.
    task automatic run_pass(input string name, input logic [2:0] m, input int twb,
                            input int h_lo, input int h_hi, input int lat, input bit keep);
        int holds, nrd, nwr, ndone, nbusy, first_rd, last_rd, first_wr, last_wr;
        int done_c, rd_err, tw_err, wr_err, sel_err, hold_err;
        bit done_seen;
        holds = (h_lo > 0) ? (h_hi - h_lo + 1) : 0;
        nrd = 0; nwr = 0; ndone = 0; nbusy = 0; done_c = -1;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        rd_err = 0; tw_err = 0; wr_err = 0; sel_err = 0; hold_err = 0;
        done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; tw_base = TW_W'(twb); hold = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = keep && !done_seen;
            hold  = (h_lo > 0) && (c >= h_lo) && (c <= h_hi);
            #1;
            if (rd_en) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                if (hold) hold_err++;
                if (int'(rd_addr) != nrd) rd_err++;
                if (int'(tw_addr) != ((twb + nrd) % 128)) tw_err++;
                nrd++;
            end
            if (wr_en) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                if (int'(wr_addr) != exp_wr_addr(nwr)) wr_err++;
                nwr++;
            end
            if (done) begin
                ndone++;
                done_c = c;
                done_seen = 1'b1;
            end
            if (busy) nbusy++;
            if ({KD_mode, sel_1, sel_0} != m) sel_err++;
        end
        start = 1'b0; hold = 1'b0;
        check({name, " rd count"},   nrd, N_BFLY);
        check({name, " first rd"},   first_rd, 1);
        check({name, " last rd"},    last_rd, N_BFLY + holds);
        check({name, " rd addr"},    rd_err, 0);
        check({name, " tw addr"},    tw_err, 0);
        check({name, " rd in hold"}, hold_err, 0);
        check({name, " wr count"},   nwr, N_BFLY);
        check({name, " first wr"},   first_wr, 1 + lat);
        check({name, " last wr"},    last_wr, N_BFLY + holds + lat);
        check({name, " wr addr"},    wr_err, 0);
        check({name, " done count"}, ndone, 1);
        check({name, " done cycle"}, done_c, N_BFLY + holds + lat + 1);
        check({name, " busy cycles"}, nbusy, N_BFLY + holds + lat);
        check({name, " mode outs"},  sel_err, 0);
    endtask

    initial begin
        int stray;
        rst = 1'b1; start = 1'b0; mode = 3'b000; tw_base = '0; hold = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outs", out_word(), 0);
        @(negedge clk);
        rst = 1'b0;

        run_pass("fwd",     3'b000, 5,   0,  0,  LAT_FWD, 1'b0);
        run_pass("kyb_inv", 3'b010, 9,   0,  0,  LAT_INV, 1'b0);
        run_pass("dil_inv", 3'b111, 100, 0,  0,  LAT_FWD, 1'b0);
        run_pass("hold",    3'b000, 5,   10, 12, LAT_FWD, 1'b0);
        run_pass("keep",    3'b001, 120, 0,  0,  LAT_FWD, 1'b1);

        // Mid-pass abort: reset at cycle 30, then silence until cycle 40.
        stray = 0;
        @(negedge clk);
        start = 1'b1; mode = 3'b000; tw_base = 7'd5;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 30) begin
                rst = 1'b1;
                #1;
                check("abort outs", out_word(), 0);
            end
            if (c == 32) rst = 1'b0;
            #1;
            if (c > 30 && (wr_en || done || busy)) stray++;
        end
        check("abort quiet", stray, 0);
        run_pass("post_rst", 3'b000, 5, 0, 0, LAT_FWD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
